// File: rtl/multiword_add_seq_pkg.sv
// Shared types and defaults for the sliced multi-word adder.
package multiword_add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mwa_state_e;

    localparam int DEF_N     = 4;
    localparam int DEF_WORDS = 4;

    // Slice index needs at least one bit even when WORDS == 1.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction
endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle between producer, adder and consumer.
interface multiword_add_seq_if
    import multiword_add_pkg::*;
    #(parameter int N = DEF_N, parameter int WORDS = DEF_WORDS);
    localparam int W = N * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, sum, carry_out, busy);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, sum, carry_out, busy);
endinterface

// File: rtl/multiword_add_seq_add_slice.sv
// Combinational N-bit ripple adder with carry-in; one instance is time-shared.
module add_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic [N:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < N; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c[N];
    end
endmodule

// File: rtl/multiword_add_seq.sv
// Adds two N*WORDS-bit operands one N-bit slice per cycle, carry chained through r_cy.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WORDS = DEF_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    multiword_add_seq_if.slave bus
);
    localparam int W    = N * WORDS;
    localparam int IDXW = idx_width(WORDS);

    mwa_state_e      r_state, w_next;
    logic [W-1:0]    r_a, r_b, r_sum;
    logic [IDXW-1:0] r_idx;
    logic            r_cy, r_co;
    logic [N-1:0]    w_sa, w_sb, w_s;
    logic            w_c, w_last;

    assign w_sa   = r_a[int'(r_idx)*N +: N];
    assign w_sb   = r_b[int'(r_idx)*N +: N];
    assign w_last = (r_idx == IDXW'(WORDS - 1));

    add_slice #(.N(N)) u_slice (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_cin  (r_cy),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = RUN;
            RUN:     if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            IDLE:    bus.in_ready = 1'b1;
            RUN:     bus.busy     = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Operands are only sampled on the accept edge; sum is overwritten slice by slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_idx <= '0;
            r_cy  <= 1'b0;
            r_co  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a   <= bus.a;
                    r_b   <= bus.b;
                    r_idx <= '0;
                    r_cy  <= 1'b0;
                end
                RUN: begin
                    r_sum[int'(r_idx)*N +: N] <= w_s;
                    r_cy  <= w_c;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) r_co <= w_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.sum       = r_sum;
    assign bus.carry_out = r_co;
endmodule
